// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: opcodes, funct3 codes, bus widths
// and the captured-access record.
package mem_stage_pkg;

  localparam int InstBus    = 32;
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  localparam logic [InstBus-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [RegBus-1:0]  ZeroWord = 32'h0000_0000;

  // Everything the stage needs to finish an access after upstream moves on.
  typedef struct packed {
    logic [InstBus-1:0]    inst;
    logic [InstBus-1:0]    inst_addr;
    logic [RegBus-1:0]     wdata;
    logic                  we;
    logic [RegAddrBus-1:0] waddr;
    logic [RegBus-1:0]     addr;
    logic [RegBus-1:0]     sdata;
    logic                  store;
    logic [2:0]            funct3;
  } mem_acc_t;

  // funct3[1:0] gives the access size: 00 byte, 01 half, otherwise word.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] a);
    logic mis;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = a[0];
      default: mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering for stores and byte/half extraction plus extension for loads.
// Purely combinational, keyed by funct3 and the low two address bits.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [RegBus-1:0] sdata_i,
  input  logic [RegBus-1:0] rdata_i,
  output logic [3:0]        be_o,
  output logic [RegBus-1:0] wdata_o,
  output logic [RegBus-1:0] ldata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = sdata_i;
    case ({1'b0, funct3_i[1:0]})
      INST_SB: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{sdata_i[7:0]}};
      end
      INST_SH: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{sdata_i[15:0]}};
      end
      INST_SW: begin
        be_o    = 4'b1111;
        wdata_o = sdata_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    ldata_o = rdata_i;
    case (funct3_i)
      INST_LB:  ldata_o = {{24{byte_sel[7]}}, byte_sel};
      INST_LBU: ldata_o = {24'h000000, byte_sel};
      INST_LH:  ldata_o = {{16{half_sel[15]}}, half_sel};
      INST_LHU: ldata_o = {16'h0000, half_sel};
      INST_LW:  ldata_o = rdata_i;
      default:  ldata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: runs loads/stores over a req/gnt/rvalid bus, stalls upstream while busy.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word ops skip the bus and flag misalign_o.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [InstBus-1:0]    inst_i,
  input  logic [InstBus-1:0]    inst_addr_i,
  input  logic [RegBus-1:0]     reg_wdata_i,
  input  logic                  reg_we_i,
  input  logic [RegAddrBus-1:0] reg_waddr_i,
  input  logic [RegBus-1:0]     op1_add_op2_res_i,
  input  logic [RegBus-1:0]     reg2_rdata_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [RegBus-1:0]     dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [RegBus-1:0]     dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [RegBus-1:0]     dmem_rdata_i,
  output logic                  valid_o,
  output logic [InstBus-1:0]    inst_o,
  output logic [InstBus-1:0]    inst_addr_o,
  output logic [RegBus-1:0]     reg_wdata_o,
  output logic                  reg_we_o,
  output logic [RegAddrBus-1:0] reg_waddr_o,
  output logic                  bus_err_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned CntW = $clog2(BUS_TIMEOUT) + 1;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(BUS_TIMEOUT - 1);

  state_e          state_q;
  mem_acc_t        acc_q;
  mem_acc_t        acc_d;
  logic [CntW-1:0] cnt_q;

  logic       is_load;
  logic       is_store;
  logic       is_mem;
  logic       mis_in;
  logic       mem_go;
  logic       in_req;
  logic       in_resp;
  logic       timeout;
  logic [3:0] be_w;
  logic [RegBus-1:0] wdata_w;
  logic [RegBus-1:0] ldata_w;

  assign is_load  = (inst_i[6:0] == INST_TYPE_L);
  assign is_store = (inst_i[6:0] == INST_TYPE_S);
  assign is_mem   = valid_i & (is_load | is_store);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_in = is_misaligned(inst_i[14:12], op1_add_op2_res_i[1:0]);
`else
  assign mis_in = 1'b0;
`endif

  assign mem_go  = is_mem & ~mis_in;
  assign in_req  = (state_q == REQ);
  assign in_resp = (state_q == RESP);
  // Counter keeps running past the limit only when a late gnt moved a load into RESP.
  assign timeout = (in_req | in_resp) & (cnt_q >= TimeoutLast);

  assign acc_d = '{
    inst:      inst_i,
    inst_addr: inst_addr_i,
    wdata:     reg_wdata_i,
    we:        reg_we_i,
    waddr:     reg_waddr_i,
    addr:      op1_add_op2_res_i,
    sdata:     reg2_rdata_i,
    store:     is_store,
    funct3:    inst_i[14:12]
  };

  mem_align u_align (
    .funct3_i  (acc_q.funct3),
    .addr_lo_i (acc_q.addr[1:0]),
    .sdata_i   (acc_q.sdata),
    .rdata_i   (dmem_rdata_i),
    .be_o      (be_w),
    .wdata_o   (wdata_w),
    .ldata_o   (ldata_w)
  );

  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      IDLE:    stall_o = mem_go;
      REQ:     stall_o = dmem_gnt_i ? ~acc_q.store : ~timeout;
      RESP:    stall_o = ~dmem_rvalid_i & ~timeout;
      default: stall_o = 1'b0;
    endcase
  end

  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req & acc_q.store;
  assign dmem_addr_o  = in_req ? {acc_q.addr[31:2], 2'b00} : ZeroWord;
  assign dmem_be_o    = in_req ? be_w : 4'b0000;
  assign dmem_wdata_o = (in_req & acc_q.store) ? wdata_w : ZeroWord;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      valid_o     <= 1'b0;
      inst_o      <= INST_NOP;
      inst_addr_o <= ZeroWord;
      reg_wdata_o <= ZeroWord;
      reg_we_o    <= 1'b0;
      reg_waddr_o <= '0;
      bus_err_o   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o  <= 1'b0;
`endif
    end else begin
      bus_err_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (mem_go) begin
            acc_q    <= acc_d;
            state_q  <= REQ;
            valid_o  <= 1'b0;
            reg_we_o <= 1'b0;
          end else begin
            valid_o     <= valid_i;
            inst_o      <= inst_i;
            inst_addr_o <= inst_addr_i;
            reg_wdata_o <= reg_wdata_i;
            reg_we_o    <= reg_we_i;
            reg_waddr_o <= reg_waddr_i;
`ifdef MEM_MISALIGN_TRAP_EN
            if (is_mem & mis_in) begin
              misalign_o <= 1'b1;
              reg_we_o   <= 1'b0;
            end
`endif
          end
        end

        REQ: begin
          cnt_q   <= cnt_q + 1'b1;
          valid_o <= 1'b0;
          if (dmem_gnt_i) begin
            if (acc_q.store) begin
              state_q     <= IDLE;
              valid_o     <= 1'b1;
              inst_o      <= acc_q.inst;
              inst_addr_o <= acc_q.inst_addr;
              reg_wdata_o <= acc_q.wdata;
              reg_we_o    <= 1'b0;
              reg_waddr_o <= acc_q.waddr;
            end else begin
              state_q <= RESP;
            end
          end else if (timeout) begin
            state_q     <= IDLE;
            valid_o     <= 1'b1;
            bus_err_o   <= 1'b1;
            inst_o      <= acc_q.inst;
            inst_addr_o <= acc_q.inst_addr;
            reg_wdata_o <= ZeroWord;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= acc_q.waddr;
          end
        end

        RESP: begin
          cnt_q   <= cnt_q + 1'b1;
          valid_o <= 1'b0;
          if (dmem_rvalid_i) begin
            state_q     <= IDLE;
            valid_o     <= 1'b1;
            inst_o      <= acc_q.inst;
            inst_addr_o <= acc_q.inst_addr;
            reg_wdata_o <= ldata_w;
            reg_we_o    <= acc_q.we;
            reg_waddr_o <= acc_q.waddr;
          end else if (timeout) begin
            state_q     <= IDLE;
            valid_o     <= 1'b1;
            bus_err_o   <= 1'b1;
            inst_o      <= acc_q.inst;
            inst_addr_o <= acc_q.inst_addr;
            reg_wdata_o <= ZeroWord;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= acc_q.waddr;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed plus randomized loads/stores/ALU ops against a behavioural bus model.
module tb_mem_stage;

  localparam int TO = 16;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam int NEVER = 1000;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
  logic misalign_o;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] inst_i, inst_addr_i, reg_wdata_i, op1_add_op2_res_i, reg2_rdata_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o, reg_we_o, bus_err_o;
  logic [31:0] inst_o, inst_addr_o, reg_wdata_o;
  logic [4:0]  reg_waddr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.BUS_TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_i           (valid_i),
    .inst_i            (inst_i),
    .inst_addr_i       (inst_addr_i),
    .reg_wdata_i       (reg_wdata_i),
    .reg_we_i          (reg_we_i),
    .reg_waddr_i       (reg_waddr_i),
    .op1_add_op2_res_i (op1_add_op2_res_i),
    .reg2_rdata_i      (reg2_rdata_i),
    .stall_o           (stall_o),
    .dmem_req_o        (dmem_req_o),
    .dmem_we_o         (dmem_we_o),
    .dmem_addr_o       (dmem_addr_o),
    .dmem_be_o         (dmem_be_o),
    .dmem_wdata_o      (dmem_wdata_o),
    .dmem_gnt_i        (dmem_gnt_i),
    .dmem_rvalid_i     (dmem_rvalid_i),
    .dmem_rdata_i      (dmem_rdata_i),
    .valid_o           (valid_o),
    .inst_o            (inst_o),
    .inst_addr_o       (inst_addr_o),
    .reg_wdata_o       (reg_wdata_o),
    .reg_we_o          (reg_we_o),
    .reg_waddr_o       (reg_waddr_o),
    .bus_err_o         (bus_err_o)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_o        (misalign_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction from accept to completion, with gnt at bus-cycle g and rvalid rv cycles after gnt.
  task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata, input int g, input int rv);
    logic [31:0] inst, wb, pc, exp_be, exp_wd, exp_ld, sh;
    logic [1:0]  a;
    bit          is_ld, is_st, mis, err, in_req;
    int          sz, end_idx, r;
    inst  = {17'h0, f3, 5'd5, opc};
    is_ld = (opc == OP_LD);
    is_st = (opc == OP_ST);
    a     = addr[1:0];
    sz    = int'(f3[1:0]);
    mis   = (sz == 1 && a[0]) || (sz >= 2 && a != 2'b00);
    wb    = $urandom;
    pc    = $urandom;

    @(negedge clk);
    valid_i = 1'b1; inst_i = inst; inst_addr_i = pc; reg_wdata_i = wb; reg_we_i = 1'b1;
    reg_waddr_i = 5'd5; op1_add_op2_res_i = addr; reg2_rdata_i = sdata; dmem_rdata_i = rdata;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    #1;

    if (!(is_ld || is_st) || (TRAP && mis)) begin
      chk("alu_stall", stall_o, 0);
      chk("alu_noreq", dmem_req_o, 0);
      @(posedge clk); #1;
      chk("alu_valid", valid_o, 1);
      chk("alu_inst", inst_o, inst);
      chk("alu_pc", inst_addr_o, pc);
      chk("alu_wdata", reg_wdata_o, wb);
      chk("alu_we", reg_we_o, (is_ld || is_st) ? 0 : 1);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("misalign", misalign_o, (is_ld || is_st) ? 1 : 0);
`endif
      return;
    end

    chk("acc_stall", stall_o, 1);

    exp_be = (sz == 0) ? (32'd1 << a) : (sz == 1) ? (a[1] ? 32'd12 : 32'd3) : 32'd15;
    exp_wd = (sz == 0) ? sdata[7:0] * 32'h01010101 :
             (sz == 1) ? sdata[15:0] * 32'h00010001 : sdata;
    sh = (sz == 0) ? (rdata >> (8 * a)) : (rdata >> (16 * a[1]));
    if (sz == 0)      exp_ld = f3[2] ? (sh & 32'hFF)   : 32'($signed(sh[7:0]));
    else if (sz == 1) exp_ld = f3[2] ? (sh & 32'hFFFF) : 32'($signed(sh[15:0]));
    else              exp_ld = rdata;

    r = g + 1 + rv;
    if (is_st) err = (g > TO - 1);
    else       err = (g > TO - 1) || (r > TO - 1);
    end_idx = err ? TO - 1 : (is_st ? g : r);

    for (int i = 0; i <= end_idx; i++) begin
      @(negedge clk);
      in_req        = (i <= g);
      dmem_gnt_i    = (i == g);
      dmem_rvalid_i = is_ld && (i == r);
      #1;
      chk("req", dmem_req_o, in_req);
      if (in_req) begin
        chk("addr", dmem_addr_o, {addr[31:2], 2'b00});
        chk("be", dmem_be_o, exp_be);
        chk("we", dmem_we_o, is_st);
        if (is_st) chk("st_wdata", dmem_wdata_o, exp_wd);
      end
      chk("stall", stall_o, (i != end_idx));
      @(posedge clk); #1;
      chk("valid", valid_o, (i == end_idx));
    end
    chk("bus_err", bus_err_o, err);
    chk("done_we", reg_we_o, (is_ld && !err));
    chk("done_inst", inst_o, inst);
    if (is_ld && !err) chk("ld_data", reg_wdata_o, exp_ld);
  endtask

  initial begin
    logic [2:0] ldf3 [5];
    int kind;
    ldf3[0] = 3'b000; ldf3[1] = 3'b001; ldf3[2] = 3'b010; ldf3[3] = 3'b100; ldf3[4] = 3'b101;

    rst = 1'b1; valid_i = 1'b0; inst_i = 32'h13; inst_addr_i = '0; reg_wdata_i = '0;
    reg_we_i = 1'b0; reg_waddr_i = '0; op1_add_op2_res_i = '0; reg2_rdata_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_inst", inst_o, 32'h13);
    chk("rst_wdata", reg_wdata_o, 0);
    chk("rst_we", reg_we_o, 0);
    chk("rst_err", bus_err_o, 0);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_stall", stall_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_op(OP_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
    run_op(OP_LD, 3'b000, 32'h1003, 32'h0, 32'h80FFFFFF, 0, 0);
    run_op(OP_ST, 3'b001, 32'h2002, 32'h0000ABCD, 32'h0, 4, 0);
    run_op(OP_LD, 3'b010, 32'h4000, 32'h0, 32'h0, NEVER, 0);
    run_op(OP_ST, 3'b010, 32'h5000, 32'h12345678, 32'h0, TO - 1, 0);
    run_op(OP_ST, 3'b000, 32'h5001, 32'h0, 32'h0, TO, 0);
    run_op(OP_LD, 3'b101, 32'h6002, 32'h0, 32'h8001C3D4, 0, TO - 2);
    run_op(OP_LD, 3'b100, 32'h6001, 32'h0, 32'h0000F500, 3, TO);
    run_op(OP_LD, 3'b010, 32'h3001, 32'h0, 32'hCAFEF00D, 0, 1);

    // Reset while a load waits in RESP; a late rvalid must be ignored.
    @(negedge clk);
    valid_i = 1'b1; inst_i = {17'h0, 3'b010, 5'd5, OP_LD}; op1_add_op2_res_i = 32'h100;
    @(negedge clk);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0; rst = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_inst", inst_o, 32'h13);
    chk("midrst_stall", stall_o, 0);
    chk("midrst_req", dmem_req_o, 0);
    @(negedge clk);
    rst = 1'b0; dmem_rvalid_i = 1'b1;
    @(posedge clk); #1;
    chk("late_rvalid", valid_o, 0);
    run_op(OP_ALU, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0)
        run_op(OP_ALU, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 0, 0);
      else if (kind == 1)
        run_op(OP_LD, ldf3[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
               $urandom_range(0, 4), $urandom_range(0, 4));
      else
        run_op(OP_ST, 3'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
               $urandom_range(0, 5), 0);
    end

    @(negedge clk);
    valid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
